// File: rtl/alu_pkg.sv
// Shared decode constants and op encoding for the execute-stage ALU.
package alu_pkg;
  localparam logic [1:0] alu_mode_add = 2'd0;
  localparam logic [1:0] alu_mode_cmp = 2'd1;
  localparam logic [1:0] alu_mode_fun = 2'd2;
  localparam logic [1:0] alu_mode_fn3 = 2'd3;

  localparam logic [6:0] f7_muldiv = 7'b0000001;

  localparam logic [2:0] br_eq  = 3'b000;
  localparam logic [2:0] br_ne  = 3'b001;
  localparam logic [2:0] br_lt  = 3'b100;
  localparam logic [2:0] br_ge  = 3'b101;
  localparam logic [2:0] br_ltu = 3'b110;
  localparam logic [2:0] br_geu = 3'b111;

  // M ops occupy 5'h10 + func3 so decode is a plain concatenation.
  typedef enum logic [4:0] {
    op_add    = 5'h00, op_sub, op_sll, op_slt, op_sltu, op_xor, op_srl, op_sra, op_or, op_and,
    op_mul    = 5'h10, op_mulh, op_mulhsu, op_mulhu, op_div, op_divu, op_rem, op_remu
  } alu_op_e;

  function automatic logic is_m_op(alu_op_e op);
    return op[4];
  endfunction
endpackage

// File: rtl/alu_exec_unit_muldiv_iter.sv
// Iterative RV32M datapath: shift-add multiply / restoring divide on magnitudes, sign fixup in FIX.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int SW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX} st_e;

  st_e               st;
  logic [SW-1:0]     step;
  logic [XLEN-1:0]   hi, lo, opd;
  logic              is_div, sel_hi, neg_q, neg_r, dz;

  logic              a_sgn, b_sgn, sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, sh, diff;
  logic [XLEN-1:0]   div_hi, q_f, r_f;
  logic [2*XLEN-1:0] prod_f;

  always_comb begin
    a_sgn  = op inside {op_mulh, op_mulhsu, op_div, op_rem};
    b_sgn  = op inside {op_mulh, op_div, op_rem};
    sa     = a_sgn & a[XLEN-1];
    sb     = b_sgn & b[XLEN-1];
    mag_a  = sa ? -a : a;
    mag_b  = sb ? -b : b;
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    sh     = {hi, lo[XLEN-1]};
    diff   = sh - {1'b0, opd};
    div_hi = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
    prod_f = neg_q ? -{hi, lo} : {hi, lo};
    // With a zero divisor every trial subtract succeeds, so hi ends up holding |a|
    // and the dividend-signed remainder is a itself; only the quotient needs overriding.
    q_f    = dz ? '1 : (neg_q ? -lo : lo);
    r_f    = neg_r ? -hi : hi;
    if (is_div) result = sel_hi ? r_f : q_f;
    else        result = sel_hi ? prod_f[2*XLEN-1:XLEN] : prod_f[XLEN-1:0];
    busy   = (st != IDLE);
    done   = (st == FIX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= IDLE;
      step   <= '0;
      hi     <= '0;
      lo     <= '0;
      opd    <= '0;
      is_div <= 1'b0;
      sel_hi <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (st)
        IDLE: if (start) begin
          hi     <= '0;
          lo     <= mag_a;
          opd    <= mag_b;
          is_div <= op inside {op_div, op_divu, op_rem, op_remu};
          sel_hi <= op inside {op_mulh, op_mulhsu, op_mulhu, op_rem, op_remu};
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          dz     <= (b == '0);
          step   <= SW'(XLEN);
          st     <= ITER;
        end
        ITER: begin
          if (is_div) begin
            hi <= div_hi;
            lo <= {lo[XLEN-2:0], ~diff[XLEN]};
          end else begin
            {hi, lo} <= {sum, lo[XLEN-1:1]};
          end
          step <= step - SW'(1);
          if (step == SW'(1)) st <= FIX;
        end
        FIX:     st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: decode, single-cycle ops, branch compare, and handshake to the iterative M unit.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [1:0]      alu_mode,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            branch_taken
);
  localparam int SHW = $clog2(XLEN);

  alu_op_e         op;
  logic            is_m, accept, lt_s, lt_u, eq, br_take;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res, md_res;
  logic            md_busy, md_done;

  always_comb begin
    op = op_add;
    if (alu_mode == alu_mode_cmp) begin
      op = op_sub;
    end else if (alu_mode == alu_mode_fun && ENABLE_M && func7 == f7_muldiv) begin
      op = alu_op_e'({2'b10, func3});
    end else if (alu_mode != alu_mode_add) begin
      case (func3)
        3'b000:  op = (alu_mode == alu_mode_fun && func7[5]) ? op_sub : op_add;
        3'b001:  op = op_sll;
        3'b010:  op = op_slt;
        3'b011:  op = op_sltu;
        3'b100:  op = op_xor;
        3'b101:  op = func7[5] ? op_sra : op_srl;
        3'b110:  op = op_or;
        default: op = op_and;
      endcase
    end
    is_m = is_m_op(op);
  end

  always_comb begin
    shamt = b[SHW-1:0];
    eq    = (a == b);
    lt_s  = ($signed(a) < $signed(b));
    lt_u  = (a < b);
    case (op)
      op_sub:  alu_res = a - b;
      op_sll:  alu_res = a << shamt;
      op_slt:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      op_sltu: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      op_xor:  alu_res = a ^ b;
      op_srl:  alu_res = a >> shamt;
      op_sra:  alu_res = $unsigned($signed(a) >>> shamt);
      op_or:   alu_res = a | b;
      op_and:  alu_res = a & b;
      default: alu_res = a + b;
    endcase
    case (func3)
      br_eq:   br_take = eq;
      br_ne:   br_take = ~eq;
      br_lt:   br_take = lt_s;
      br_ge:   br_take = ~lt_s;
      br_ltu:  br_take = lt_u;
      br_geu:  br_take = ~lt_u;
      default: br_take = 1'b0;
    endcase
  end

  assign accept = start & ~busy;
  assign busy   = md_busy;

  generate
    if (ENABLE_M) begin : g_md
      muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (accept & is_m),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_res)
      );
    end else begin : g_no_md
      assign md_busy = 1'b0;
      assign md_done = 1'b0;
      assign md_res  = '0;
    end
  endgenerate

  // Base accept and M completion are exclusive: the M unit holds busy through FIX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done         <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
    end else if (accept && !is_m) begin
      done         <= 1'b1;
      result       <= alu_res;
      branch_taken <= (alu_mode == alu_mode_cmp) & br_take;
    end else if (md_done) begin
      done         <= 1'b1;
      result       <= md_res;
      branch_taken <= 1'b0;
    end else begin
      done         <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  alu_mode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] a, b;
  logic        busy, done, branch_taken;
  logic [31:0] result;

  int nvec = 0;
  int nmis = 0;

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .alu_mode    (alu_mode),
    .func3       (func3),
    .func7       (func7),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] va, input logic [31:0] vb);
    alu_mode = m; func3 = f3; func7 = f7; a = va; b = vb; start = 1'b1;
  endtask

  // Single-cycle op: done and result checked #1 after the accepting edge.
  task automatic base_op(input string tag, input logic [1:0] m, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp_res, input logic exp_bt);
    @(negedge clk);
    drive(m, f3, f7, va, vb);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_bt"}, {31'd0, branch_taken}, {31'd0, exp_bt});
  endtask

  // M op: count cycles with busy high after the accepting edge, then expect done.
  task automatic m_op(input string tag, input logic [2:0] f3, input logic [31:0] va,
                      input logic [31:0] vb, input logic [31:0] exp_res);
    int cnt;
    @(negedge clk);
    drive(2'd2, f3, 7'b0000001, va, vb);
    @(posedge clk); #1;
    start = 1'b0;
    a = 32'hDEADBEEF; b = 32'h0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(posedge clk); #1;
    end
    chk({tag, "_lat"}, cnt, 32'd33);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_bt"}, {31'd0, branch_taken}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0;
    alu_mode = 2'd0; func3 = 3'd0; func7 = 7'd0; a = '0; b = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_bt", {31'd0, branch_taken}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    base_op("sub",   2'd2, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'hFFFFFFFE, 1'b0);
    base_op("addi",  2'd3, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'd12, 1'b0);
    base_op("sra",   2'd2, 3'b101, 7'b0100000, 32'h80000000, 32'h21, 32'hC0000000, 1'b0);
    base_op("srl",   2'd2, 3'b101, 7'b0000000, 32'h80000000, 32'h21, 32'h40000000, 1'b0);
    base_op("sll",   2'd3, 3'b001, 7'b0000000, 32'h00000003, 32'h24, 32'h00000030, 1'b0);
    base_op("blt",   2'd1, 3'b100, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b1);
    base_op("bltu",  2'd1, 3'b110, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFE, 1'b0);
    base_op("b010",  2'd1, 3'b010, 7'b0000000, 32'd9, 32'd9, 32'd0, 1'b0);
    base_op("beq",   2'd1, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'd0, 1'b1);
    base_op("add",   2'd0, 3'b111, 7'b0100000, 32'hFFFFFFFF, 32'd2, 32'd1, 1'b0);
    base_op("slt",   2'd3, 3'b010, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
    base_op("sltu",  2'd3, 3'b011, 7'b0000000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
    base_op("xor",   2'd2, 3'b100, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0);
    base_op("and",   2'd2, 3'b111, 7'b0000000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);

    // back-to-back base starts keep done high
    @(negedge clk);
    drive(2'd0, 3'd0, 7'd0, 32'd10, 32'd20);
    @(posedge clk); #1;
    chk("b2b_d1", {31'd0, done}, 32'd1);
    chk("b2b_r1", result, 32'd30);
    @(negedge clk);
    drive(2'd2, 3'b110, 7'd0, 32'h0000F000, 32'h0000000F);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_d2", {31'd0, done}, 32'd1);
    chk("b2b_r2", result, 32'h0000F00F);
    @(posedge clk); #1;
    chk("b2b_d3", {31'd0, done}, 32'd0);

    m_op("mulh",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    m_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    m_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    m_op("mul",    3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
    m_op("divov",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    m_op("remz",   3'b110, 32'd13, 32'd0, 32'd13);
    m_op("divuz",  3'b101, 32'd55, 32'd0, 32'hFFFFFFFF);
    m_op("divn",   3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    m_op("remn",   3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    m_op("remu",   3'b111, 32'd100, 32'd7, 32'd2);

    // start ignored while busy, then reset aborts the multiply
    @(negedge clk);
    drive(2'd2, 3'b000, 7'b0000001, 32'd3, 32'd4);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    drive(2'd0, 3'd0, 7'd0, 32'd1, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_done", {31'd0, done}, 32'd0);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_res", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) break;
    end
    chk("post_rst_done", {31'd0, done}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    base_op("post_add", 2'd0, 3'd0, 7'd0, 32'd2, 32'd3, 32'd5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, sequential successor to the combinational ALU decoder. It decodes `alu_mode`/`func3`/`func7` exactly as the decoder does and executes the operation. The unit also evaluates branch conditions and adds an iterative RV32M multiply/divide path behind a start/busy/done handshake. It sits in the execute stage of the multicycle core, driven by the control FSM.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; must be a power of two, ≥ 8.
- `ENABLE_M`, 1: 1 enables the MUL/DIV family; 0 decodes `func7 = 7'b0000001` as a base op.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy = 0`.
- `alu_mode`  in  2  mode: 0 add, 1 cmp/branch, 2 R-type, 3 I-type.
- `func3`  in  3  instruction func3.
- `func7`  in  7  instruction func7.
- `a`, `b`  in  XLEN  operands, sampled at the accepting edge.
- `busy`  out  1  multi-cycle operation in flight.
- `done`  out  1  one-cycle pulse; `result` and `branch_taken` are valid while it is high.
- `result`  out  XLEN  registered result, held until the next `done`.
- `branch_taken`  out  1  registered branch decision, mode 1 only; otherwise 0.

## Operation
- Mode 0: `result = a + b`, modulo 2^XLEN.
- Mode 1: `result = a - b`. `branch_taken` by func3:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 give 0.
- Mode 2, base ops (func7 ≠ 0000001, or `ENABLE_M = 0`):
  - func3 000: add, or sub if `func7[5]`.
  - 001 sll, 010 slt, 011 sltu, 100 xor.
  - 101: srl, or sra if `func7[5]`.
  - 110 or, 111 and.
- Mode 3: same as mode 2, except func3 000 is always add. sra/srl still use `func7[5]`. The M family is never selected.
- Shift amount is `b[$clog2(XLEN)-1:0]`. slt/sltu write 0 or 1, zero-extended.
- M family (mode 2, func7 = 0000001, `ENABLE_M = 1`), by func3:
  - 000 MUL: low XLEN bits.
  - 001 MULH (s×s), 010 MULHSU (s×u), 011 MULHU (u×u): high XLEN bits.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Multiply is shift-add on magnitudes into a 2·XLEN accumulator. The product is negated at the end iff the operand signs differ (signed operands only).
- Divide is restoring division on magnitudes:
  - quotient is negated iff the signs differ;
  - remainder takes the sign of the dividend.
- Divide special cases (the latency is not shortened):
  - divisor 0: quotient all-ones; remainder = `a`.
  - signed `-2^(XLEN-1) / -1`: quotient = `a`; remainder 0.

FSM states: IDLE, ITER, FIX.
- IDLE, `start` with a base op: register the result, pulse `done`, stay in IDLE.
- IDLE, `start` with an M op: latch magnitudes and signs, set `step = XLEN`, go to ITER, `busy = 1`.
- ITER: one shift-add or restore step per cycle, `step` decrements. When `step` reaches 1, go to FIX.
- FIX: apply sign/special-case fixup, register the result, pulse `done`, clear `busy`, return to IDLE.

## Timing
- Reset (async assert, sync release): IDLE, `busy = 0`, `done = 0`, `result = 0`, `branch_taken = 0`, internal counters and accumulators cleared.
- Reset mid-operation aborts with no `done`.
- Base op accepted at edge k: `done = 1` for the cycle after edge k, with `result` valid.
  - Back-to-back base starts every cycle are legal; `done` stays high.
- M op accepted at edge k:
  - `busy = 1` after edges k … k+XLEN;
  - `done = 1` and `busy = 0` after edge k+XLEN+1.
  - Latency is XLEN+1 cycles, fixed.
- `start` while `busy = 1` is ignored, not queued. Operand changes during `busy` have no effect.
- A new `start` is accepted in the same cycle `done` is high, since `busy = 0` there.

## Structure
- Package `alu_pkg` holds:
  - mode constants (`alu_mode_add/cmp/fun/fn3`);
  - a 5-bit op enum: the base ops plus `op_mul`, `op_mulh`, `op_mulhsu`, `op_mulhu`, `op_div`, `op_divu`, `op_rem`, `op_remu`;
  - the `func7` M constant;
  - branch func3 codes.
- Sub-module `muldiv_iter` holds the ITER/FIX datapath and step counter, with its own start/done. It is instantiated only when `ENABLE_M = 1`.
- The top level holds the decode, the single-cycle ALU, branch compare and the handshake mux.

## Test plan
- Mode 2, func3 000, func7 0100000, a=5, b=7 → next cycle `done=1`, `result=0xFFFFFFFE`. The same inputs in mode 3 → `result=12`.
- Mode 2, func3 101, func7 0100000, a=0x80000000, b=0x21 → `result=0xC0000000`. Checks that shamt masks to 1.
- Mode 1, func3 100, a=0xFFFFFFFF, b=1 → `branch_taken=1`. The same with func3 110 → 0.
- MULH, a=0xFFFFFFFF, b=0xFFFFFFFF:
  - `busy` is high for 33 cycles;
  - `done` comes at cycle 33 with `result=0`;
  - MULHU gives 0xFFFFFFFE.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000. REM by 0 with a=13 → 13. DIVU by 0 → 0xFFFFFFFF.
- Start MUL, pulse `start` again at cycle 5 (ignored), then assert `reset_n=0` at cycle 10:
  - outputs 0 immediately, no `done`;
  - a post-reset ADD 2+3 → 5.
